// File: rtl/enoc_wormhole_switch_ctrl.sv
// Wormhole switch allocator: per-output round-robin arbitration that stays locked
// to the winning input until that input's tail flit has been granted.
module enoc_wormhole_switch_ctrl #(
   parameter int N = 5,
   parameter int M = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ce,
   input  logic [0:M-1]           i_en,
   input  logic [0:N-1][0:M-1]    i_output_req,
   input  logic [0:N-1]           i_tail,
   output logic [0:M-1][0:N-1]    o_output_grant,
   output logic [0:N-1]           o_input_grant,
   output logic [0:M-1]           o_locked,
   output logic                   o_req_err
);

   localparam int W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t         state_q  [M];
   state_t         state_d  [M];
   logic [W-1:0]   rr_ptr_q [M];
   logic [W-1:0]   rr_ptr_d [M];
   logic [W-1:0]   owner_q  [M];
   logic [W-1:0]   owner_d  [M];
   logic           req_err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < M; j++) begin
            state_q[j]  <= IDLE;
            rr_ptr_q[j] <= '0;
            owner_q[j]  <= '0;
         end
         o_req_err <= 1'b0;
      end else if (ce) begin
         for (int j = 0; j < M; j++) begin
            state_q[j]  <= state_d[j];
            rr_ptr_q[j] <= rr_ptr_d[j];
            owner_q[j]  <= owner_d[j];
         end
         o_req_err <= req_err_d;
      end
   end

   // Grants are purely combinational; next state only matters when ce=1 and reset=0.
   always_comb begin
      logic         found;
      logic [W-1:0] winner;
      int           idx;
      o_output_grant = '0;
      found          = 1'b0;
      winner         = '0;
      idx            = 0;
      for (int j = 0; j < M; j++) begin
         state_d[j]  = state_q[j];
         rr_ptr_d[j] = rr_ptr_q[j];
         owner_d[j]  = owner_q[j];
      end
      if (ce && !reset) begin
         for (int j = 0; j < M; j++) begin
            if (state_q[j] == LOCKED) begin
               if (i_en[j] && i_output_req[owner_q[j]][j]) begin
                  o_output_grant[j][owner_q[j]] = 1'b1;
                  if (i_tail[owner_q[j]]) begin
                     state_d[j] = IDLE;
                  end
               end
            end else if (i_en[j]) begin
               found  = 1'b0;
               winner = '0;
               for (int k = 0; k < N; k++) begin
                  idx = int'(rr_ptr_q[j]) + k;
                  if (idx >= N) begin
                     idx = idx - N;
                  end
                  if (!found && i_output_req[idx][j]) begin
                     found  = 1'b1;
                     winner = W'(idx);
                  end
               end
               if (found) begin
                  o_output_grant[j][winner] = 1'b1;
                  rr_ptr_d[j] = (winner == W'(N - 1)) ? '0 : winner + 1'b1;
                  if (!i_tail[winner]) begin
                     state_d[j] = LOCKED;
                     owner_d[j] = winner;
                  end
               end
            end
         end
      end
   end

   // A request vector with more than one bit set trips the sticky error flag.
   always_comb begin
      logic [0:M-1] r;
      r         = '0;
      req_err_d = o_req_err;
      for (int i = 0; i < N; i++) begin
         r = i_output_req[i];
         if ((r & (r - 1'b1)) != '0) begin
            req_err_d = 1'b1;
         end
      end
   end

   always_comb begin
      o_input_grant = '0;
      for (int j = 0; j < M; j++) begin
         for (int i = 0; i < N; i++) begin
            o_input_grant[i] = o_input_grant[i] | o_output_grant[j][i];
         end
      end
   end

   always_comb begin
      o_locked = '0;
      for (int j = 0; j < M; j++) begin
         o_locked[j] = (state_q[j] == LOCKED);
      end
   end

endmodule

// File: tb/tb_enoc_wormhole_switch_ctrl.sv
// Directed scoreboard bench for the wormhole switch allocator: each stimulus cycle
// queues its hand-computed response, and a negedge monitor pops and compares.
module tb_enoc_wormhole_switch_ctrl;

   localparam int N = 5;
   localparam int M = 5;

   logic                 clk;
   logic                 reset;
   logic                 ce;
   logic [0:M-1]         i_en;
   logic [0:N-1][0:M-1]  i_output_req;
   logic [0:N-1]         i_tail;
   logic [0:M-1][0:N-1]  o_output_grant;
   logic [0:N-1]         o_input_grant;
   logic [0:M-1]         o_locked;
   logic                 o_req_err;

   typedef struct {
      string                name;
      logic [0:M-1][0:N-1]  og;
      logic [0:M-1]         lk;
      logic                 err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   enoc_wormhole_switch_ctrl #(.N(N), .M(M)) dut (
      .clk            (clk),
      .reset          (reset),
      .ce             (ce),
      .i_en           (i_en),
      .i_output_req   (i_output_req),
      .i_tail         (i_tail),
      .o_output_grant (o_output_grant),
      .o_input_grant  (o_input_grant),
      .o_locked       (o_locked),
      .o_req_err      (o_req_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Request matrix from per-input target output (-1 = no request).
   function automatic logic [0:N-1][0:M-1] reqs(input int t0, t1, t2, t3, t4);
      int t[5];
      logic [0:N-1][0:M-1] r;
      t = '{t0, t1, t2, t3, t4};
      r = '0;
      for (int i = 0; i < N; i++) if (t[i] >= 0) r[i][t[i]] = 1'b1;
      return r;
   endfunction

   // Grant matrix from per-output granted input (-1 = no grant).
   function automatic logic [0:M-1][0:N-1] ogs(input int g0, g1, g2, g3, g4);
      int g[5];
      logic [0:M-1][0:N-1] r;
      g = '{g0, g1, g2, g3, g4};
      r = '0;
      for (int j = 0; j < M; j++) if (g[j] >= 0) r[j][g[j]] = 1'b1;
      return r;
   endfunction

   function automatic logic [0:N-1] ig_of(input logic [0:M-1][0:N-1] og);
      logic [0:N-1] r;
      r = '0;
      for (int j = 0; j < M; j++) r = r | og[j];
      return r;
   endfunction

   task automatic applyStimulus(input string name, input logic rst, input logic c,
                                input logic [0:M-1] en, input logic [0:N-1][0:M-1] req,
                                input logic [0:N-1] tail, input logic [0:M-1][0:N-1] exp_og,
                                input logic [0:M-1] exp_lk, input logic exp_err);
      exp_t e;
      @(posedge clk);
      #1;
      reset        = rst;
      ce           = c;
      i_en         = en;
      i_output_req = req;
      i_tail       = tail;
      e.name = name;
      e.og   = exp_og;
      e.lk   = exp_lk;
      e.err  = exp_err;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      logic [0:N-1] exp_ig;
      exp_ig = ig_of(e.og);
      checks++;
      if (o_output_grant !== e.og) begin
         errors++;
         $display("[TB] FAIL %s output_grant got %h expected %h", e.name, o_output_grant, e.og);
      end
      checks++;
      if (o_input_grant !== exp_ig) begin
         errors++;
         $display("[TB] FAIL %s input_grant got %b expected %b", e.name, o_input_grant, exp_ig);
      end
      checks++;
      if (o_locked !== e.lk) begin
         errors++;
         $display("[TB] FAIL %s locked got %b expected %b", e.name, o_locked, e.lk);
      end
      checks++;
      if (o_req_err !== e.err) begin
         errors++;
         $display("[TB] FAIL %s req_err got %b expected %b", e.name, o_req_err, e.err);
      end
   endtask

   // Monitor: compares whatever the DUT is presenting mid-cycle against the queued response.
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) checkOutput(sb.pop_front());
      end
   end

   initial begin
      logic [0:N-1][0:M-1] all_req;
      logic [0:N-1][0:M-1] bad_req;
      int wait_cycles;
      all_req = '1;
      bad_req = '0;
      bad_req[2] = 5'b00110;

      reset = 1'b1; ce = 1'b1; i_en = '1; i_output_req = all_req; i_tail = '1;
      $display("[TB] start");

      // Reset holds grants and state at zero even with every request high
      applyStimulus("rst0", 1, 1, 5'b11111, all_req, 5'b11111, '0, 5'b00000, 0);
      applyStimulus("rst1", 1, 1, 5'b11111, all_req, 5'b11111, '0, 5'b00000, 0);
      applyStimulus("rst2", 1, 1, 5'b11111, all_req, 5'b11111, '0, 5'b00000, 0);

      // Round robin on output 2 between inputs 0 and 1
      applyStimulus("rr_a", 0, 1, 5'b11111, reqs(2, 2, -1, -1, -1), 5'b11000, ogs(-1, -1, 0, -1, -1), 5'b00000, 0);
      applyStimulus("rr_b", 0, 1, 5'b11111, reqs(2, 2, -1, -1, -1), 5'b11000, ogs(-1, -1, 1, -1, -1), 5'b00000, 0);

      // Input 3 locks output 1 while input 4 waits
      applyStimulus("lock_f1", 0, 1, 5'b11111, reqs(-1, -1, -1, 1, 1), 5'b00001, ogs(-1, 3, -1, -1, -1), 5'b00000, 0);
      applyStimulus("lock_f2", 0, 1, 5'b11111, reqs(-1, -1, -1, 1, 1), 5'b00001, ogs(-1, 3, -1, -1, -1), 5'b01000, 0);
      applyStimulus("bp_1",    0, 1, 5'b10111, reqs(-1, -1, -1, 1, 1), 5'b00001, ogs(-1, -1, -1, -1, -1), 5'b01000, 0);
      applyStimulus("bp_2",    0, 1, 5'b10111, reqs(-1, -1, -1, 1, 1), 5'b00001, ogs(-1, -1, -1, -1, -1), 5'b01000, 0);
      applyStimulus("bubble",  0, 1, 5'b11111, reqs(-1, -1, -1, -1, 1), 5'b00001, ogs(-1, -1, -1, -1, -1), 5'b01000, 0);
      applyStimulus("lock_f3", 0, 1, 5'b11111, reqs(-1, -1, -1, 1, 1), 5'b00001, ogs(-1, 3, -1, -1, -1), 5'b01000, 0);
      applyStimulus("lock_f4", 0, 1, 5'b11111, reqs(-1, -1, -1, 1, 1), 5'b00011, ogs(-1, 3, -1, -1, -1), 5'b01000, 0);
      applyStimulus("unlock",  0, 1, 5'b11111, reqs(-1, -1, -1, -1, 1), 5'b00001, ogs(-1, 4, -1, -1, -1), 5'b00000, 0);

      // Three independent single-flit grants in one cycle
      applyStimulus("parallel", 0, 1, 5'b11111, reqs(0, 1, 2, -1, -1), 5'b11111, ogs(0, 1, 2, -1, -1), 5'b00000, 0);

      // Bring output 3 pointer to 4, freeze with ce=0, then check wrap 4 -> 0
      applyStimulus("ptr4",   0, 1, 5'b11111, reqs(-1, -1, -1, 3, -1), 5'b11111, ogs(-1, -1, -1, 3, -1), 5'b00000, 0);
      applyStimulus("ce_off1", 0, 0, 5'b11111, reqs(3, -1, -1, -1, 3), 5'b11111, '0, 5'b00000, 0);
      applyStimulus("ce_off2", 0, 0, 5'b11111, reqs(3, -1, -1, -1, 3), 5'b11111, '0, 5'b00000, 0);
      applyStimulus("wrap_a", 0, 1, 5'b11111, reqs(3, -1, -1, -1, 3), 5'b11111, ogs(-1, -1, -1, 4, -1), 5'b00000, 0);
      applyStimulus("wrap_b", 0, 1, 5'b11111, reqs(3, -1, -1, -1, 3), 5'b11111, ogs(-1, -1, -1, 0, -1), 5'b00000, 0);

      // Multi-hot request: both bits arbitrated, error latches next cycle
      applyStimulus("mhot",   0, 1, 5'b11111, bad_req, 5'b11111, ogs(-1, -1, 2, 2, -1), 5'b00000, 0);
      applyStimulus("sticky", 0, 1, 5'b11111, '0, 5'b11111, '0, 5'b00000, 1);

      // Reset while output 1 is locked clears lock, error and pointer
      applyStimulus("rl_head", 0, 1, 5'b11111, reqs(-1, -1, -1, 1, -1), 5'b00000, ogs(-1, 3, -1, -1, -1), 5'b00000, 1);
      applyStimulus("rl_body", 0, 1, 5'b11111, reqs(-1, -1, -1, 1, -1), 5'b00000, ogs(-1, 3, -1, -1, -1), 5'b01000, 1);
      applyStimulus("rl_rst",  1, 1, 5'b11111, reqs(-1, -1, -1, 1, -1), 5'b00000, '0, 5'b01000, 1);
      applyStimulus("rl_post", 0, 1, 5'b11111, reqs(-1, 1, -1, -1, 1), 5'b11111, ogs(-1, 1, -1, -1, -1), 5'b00000, 0);

      wait_cycles = 0;
      while (sb.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain scoreboard left %0d required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/enoc_wormhole_switch_ctrl.md
Name: enoc_wormhole_switch_ctrl

Overview:
Packet-locking switch allocator for the ENoC crossbar, used with wormhole flow control. Each output port runs its own round-robin arbitration among the inputs requesting it. Once a winner's head flit is granted, that output stays locked to the winning input until the input's tail flit is granted. Crossbar select lines and input-unit dequeue strobes are generated directly from this block.

Parameters:
N, 5, number of input ports (≥2)
M, 5, number of output ports (≥2)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ce  input  1  clock enable; all state updates and grants qualified by ce
i_en  input  [0:M-1]  downstream ready per output port
i_output_req  input  [0:N-1][0:M-1]  per-input one-hot (or zero) requested output for the flit at its head
i_tail  input  [0:N-1]  flit at input head is a tail (single-flit packet = head+tail, i_tail=1)
o_output_grant  output  [0:M-1][0:N-1]  per-output one-hot granted input (crossbar select)
o_input_grant  output  [0:N-1]  input dequeue strobe = OR over outputs of o_output_grant[j][i]
o_locked  output  [0:M-1]  output currently held by a multi-flit packet
o_req_err  output  1  sticky; set when any i_output_req[i] has >1 bit set

Behaviour:
- Reset is synchronous, active-high, and overrides ce. On reset: every output goes IDLE, owner=0, rr_ptr=0, o_locked=0, o_req_err=0.
- While reset=1, o_output_grant=0 and o_input_grant=0.
- Grants are combinational from current state and inputs (0-cycle latency). State updates on posedge clk when ce=1. When ce=0, all grants are forced to 0 and state holds.
- Per-output FSM, output j:
  - IDLE:
    - Candidates = {i : i_output_req[i][j]}.
    - If i_en[j]=1 and the candidate set is non-empty, grant the first candidate searching rr_ptr, rr_ptr+1, … mod N.
    - On a grant, rr_ptr ← (winner+1) mod N.
    - If i_tail[winner]=0: next state LOCKED, owner ← winner. Otherwise stay IDLE (single-flit packet).
    - If i_en[j]=0: no grant, rr_ptr unchanged.
  - LOCKED:
    - Grant owner only if i_output_req[owner][j]=1 and i_en[j]=1. All other requests to j are ignored.
    - If the owner's request is absent, or i_en[j]=0, there is no grant and the output stays LOCKED (bubble or backpressure).
    - Granted flit with i_tail[owner]=1 → IDLE next cycle.
    - rr_ptr does not move while LOCKED.
- o_locked[j] = (state_j == LOCKED), registered.
- A new packet may win output j in the cycle after the tail is granted. The tail cycle itself grants only the owner.
- Malformed request: if an input has a multi-hot request, o_req_err sets and stays set until reset. Arbitration still treats each bit as an independent request.
- One-hot requests guarantee at most one grant per input per cycle, so o_input_grant is one-hot-safe.
- Arithmetic: rr_ptr and owner are $clog2(N) bits. rr_ptr wrap: (N-1)+1 → 0.

Test Plan:
- Reset: hold reset=1 with all requests high for 3 cycles → all grants 0, o_locked=0. Release; inputs 0 and 1 both request output 2 with tail=1, en=1 → cycle 1 grants input 0, cycle 2 grants input 1 (rr_ptr 1→2).
- Lock: input 3 sends head (tail=0) to output 1; input 4 also requests output 1 → input 3 granted for 4 flits, tail on flit 4; o_locked[1]=1 for cycles 2–4; input 4 granted in cycle 5.
- Backpressure and bubble mid-packet: drive i_en[1]=0 for 2 cycles, then owner request=0 for 1 cycle → no grants, o_locked stays 1, input 4 never granted until the owner's tail.
- Parallel outputs: inputs 0→out0, 1→out1, 2→out2 simultaneously, all single-flit → three grants in the same cycle; o_input_grant=5'b11100.
- ce gating and wrap: with ce=0 for 2 cycles, grants=0 and state frozen. With rr_ptr=4 (N=5), requests from inputs 4 and 0 → input 4 granted, then rr_ptr=0 and input 0 granted next.
- Error and reset mid-packet: input 2 requests 5'b00110 → o_req_err=1 sticky. Assert reset while output 1 is LOCKED → next cycle o_locked=0, rr_ptr=0.
